// File: rtl/pipe_mem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction: issues req/ack
// transactions, stalls the front pipeline, discards killed loads, bounds accesses by timeout.
module pipe_mem_access_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_MASK_WIDTH  = 3,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int TIMER_WIDTH     = 7,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Mem_Valid,
    input  logic                       i_Mem_Read_Write_n,
    input  logic [MEM_MASK_WIDTH-1:0]  i_Mem_Mask,
    input  logic                       i_Kill,
    input  logic                       i_Mem_Ack,
    input  logic [DATA_WIDTH-1:0]      i_Mem_Read_Data,
    output logic                       o_Mem_Req,
    output logic                       o_Mem_Read_Write_n,
    output logic [MEM_MASK_WIDTH-1:0]  o_Mem_Mask,
    output logic                       o_Stall,
    output logic [DATA_WIDTH-1:0]      o_Load_Data,
    output logic                       o_Load_Data_Valid,
    output logic                       o_Mem_Error,
    output logic [STALL_CNT_WIDTH-1:0] o_Stall_Count
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SQUASH} state_t;

    state_t                     r_state, w_next;
    logic [TIMER_WIDTH-1:0]     r_timer;
    logic                       r_mem_req, r_rw_n, r_ld_vld, r_err;
    logic [MEM_MASK_WIDTH-1:0]  r_mask;
    logic [DATA_WIDTH-1:0]      r_ld_data;
    logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

    logic w_stall, w_issue, w_done, w_ld_pulse, w_err, w_timeout;

    assign w_timeout = (r_timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_issue    = 1'b0;
        w_done     = 1'b0;
        w_ld_pulse = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Mem_Valid && !i_Kill) begin
                    w_stall = 1'b1;
                    w_issue = 1'b1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_stall = !i_Mem_Ack || i_Kill;
                if (i_Mem_Ack) begin
                    w_done     = 1'b1;
                    w_ld_pulse = !i_Kill && r_rw_n;
                    w_next     = S_IDLE;
                end else if (w_timeout) begin
                    // Timeout wins over a same-cycle kill: the access is over either way.
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (i_Kill) begin
                    w_next = S_SQUASH;
                end
            end
            S_SQUASH: begin
                // Request stays up until ack; the response is simply dropped.
                w_stall = 1'b1;
                if (i_Mem_Ack) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_mem_req   <= 1'b0;
            r_rw_n      <= 1'b0;
            r_mask      <= '0;
            r_ld_vld    <= 1'b0;
            r_ld_data   <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_ld_vld <= w_ld_pulse;
            r_err    <= w_err;
            if (w_ld_pulse)
                r_ld_data <= i_Mem_Read_Data;
            if (w_issue) begin
                r_mem_req <= 1'b1;
                r_rw_n    <= i_Mem_Read_Write_n;
                r_mask    <= i_Mem_Mask;
                r_timer   <= '0;
            end else if (w_done) begin
                r_mem_req <= 1'b0;
                r_timer   <= '0;
            end else if (r_state != S_IDLE) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_stall && (r_stall_cnt != {STALL_CNT_WIDTH{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_Mem_Req          = r_mem_req;
    assign o_Mem_Read_Write_n = r_rw_n;
    assign o_Mem_Mask         = r_mask;
    assign o_Stall            = w_stall;
    assign o_Load_Data        = r_ld_data;
    assign o_Load_Data_Valid  = r_ld_vld;
    assign o_Mem_Error        = r_err;
    assign o_Stall_Count      = r_stall_cnt;

endmodule

// File: tb/tb_pipe_mem_access_ctrl.sv
// Bench for pipe_mem_access_ctrl: directed table, random traffic against a
// transaction-level model, timeout on a short-timeout instance, reset and saturation.
module tb_pipe_mem_access_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        i_Reset, i_Mem_Valid, i_Mem_Read_Write_n, i_Kill, i_Mem_Ack;
    logic [2:0]  i_Mem_Mask;
    logic [31:0] i_Mem_Read_Data;
    logic        o_Mem_Req, o_Mem_Read_Write_n, o_Stall, o_Load_Data_Valid, o_Mem_Error;
    logic [2:0]  o_Mem_Mask;
    logic [31:0] o_Load_Data;
    logic [15:0] o_Stall_Count;

    logic        t_rst, t_valid, t_ack;
    logic        t_req, t_rw, t_stall, t_ldv, t_err;
    logic [2:0]  t_mask;
    logic [31:0] t_ld;
    logic [15:0] t_cnt;

    always #5 clk = ~clk;

    pipe_mem_access_ctrl u_dut (
        .i_Clk(clk), .i_Reset(i_Reset), .i_Mem_Valid(i_Mem_Valid),
        .i_Mem_Read_Write_n(i_Mem_Read_Write_n), .i_Mem_Mask(i_Mem_Mask),
        .i_Kill(i_Kill), .i_Mem_Ack(i_Mem_Ack), .i_Mem_Read_Data(i_Mem_Read_Data),
        .o_Mem_Req(o_Mem_Req), .o_Mem_Read_Write_n(o_Mem_Read_Write_n),
        .o_Mem_Mask(o_Mem_Mask), .o_Stall(o_Stall), .o_Load_Data(o_Load_Data),
        .o_Load_Data_Valid(o_Load_Data_Valid), .o_Mem_Error(o_Mem_Error),
        .o_Stall_Count(o_Stall_Count)
    );

    pipe_mem_access_ctrl #(.TIMEOUT_CYCLES(4), .TIMER_WIDTH(3)) u_dut4 (
        .i_Clk(clk), .i_Reset(t_rst), .i_Mem_Valid(t_valid),
        .i_Mem_Read_Write_n(1'b1), .i_Mem_Mask(3'b111),
        .i_Kill(1'b0), .i_Mem_Ack(t_ack), .i_Mem_Read_Data(32'h0),
        .o_Mem_Req(t_req), .o_Mem_Read_Write_n(t_rw),
        .o_Mem_Mask(t_mask), .o_Stall(t_stall), .o_Load_Data(t_ld),
        .o_Load_Data_Valid(t_ldv), .o_Mem_Error(t_err),
        .o_Stall_Count(t_cnt)
    );

    int vectors = 0, miscompares = 0;

    // Reference model: one outstanding access, its age, and whether it was killed.
    logic        m_out, m_dead, m_rw, m_ldv, m_err;
    logic [2:0]  m_mk;
    logic [31:0] m_ld;
    int          m_age, m_cnt;
    logic        s_stall;

    typedef struct {
        logic v, rw; logic [2:0] mk; logic k, a; logic [31:0] d;
        logic e_st, e_req, e_ldv; logic [15:0] e_cnt; logic [31:0] e_ld;
    } vec_t;
    vec_t tbl[29];

    function automatic vec_t mkv(logic v, logic rw, logic [2:0] mk, logic k, logic a,
                                 logic [31:0] d, logic st, logic rq, logic ldv,
                                 logic [15:0] cnt, logic [31:0] ld);
        vec_t r;
        r.v = v; r.rw = rw; r.mk = mk; r.k = k; r.a = a; r.d = d;
        r.e_st = st; r.e_req = rq; r.e_ldv = ldv; r.e_cnt = cnt; r.e_ld = ld;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic rw, input logic [2:0] mk,
                        input logic k, input logic a, input logic [31:0] d);
        logic e_st;
        i_Reset = rst; i_Mem_Valid = v; i_Mem_Read_Write_n = rw; i_Mem_Mask = mk;
        i_Kill = k; i_Mem_Ack = a; i_Mem_Read_Data = d;
        e_st = !m_out ? (v && !k) : (m_dead ? 1'b1 : (!a || k));
        @(negedge clk);
        s_stall = o_Stall;
        chk("stall", {31'b0, o_Stall}, {31'b0, e_st});
        if (rst) begin
            m_out = 0; m_dead = 0; m_age = 0; m_rw = 0; m_mk = 0;
            m_ldv = 0; m_ld = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (e_st && m_cnt < 65535) m_cnt++;
            m_ldv = 0; m_err = 0;
            if (!m_out) begin
                if (v && !k) begin
                    m_out = 1; m_dead = 0; m_age = 0; m_rw = rw; m_mk = mk;
                end
            end else if (a) begin
                m_out = 0;
                if (!m_dead && !k && m_rw) begin m_ldv = 1; m_ld = d; end
            end else if (m_age == TO - 1) begin
                m_out = 0; m_err = 1;
            end else begin
                m_age++;
                if (k) m_dead = 1;
            end
        end
        @(posedge clk); #1;
        chk("req", {31'b0, o_Mem_Req}, {31'b0, m_out});
        chk("ld_valid", {31'b0, o_Load_Data_Valid}, {31'b0, m_ldv});
        chk("ld_data", o_Load_Data, m_ld);
        chk("mem_error", {31'b0, o_Mem_Error}, {31'b0, m_err});
        chk("stall_cnt", {16'b0, o_Stall_Count}, m_cnt);
        if (m_out) begin
            chk("req_rw", {31'b0, o_Mem_Read_Write_n}, {31'b0, m_rw});
            chk("req_mask", {29'b0, o_Mem_Mask}, {29'b0, m_mk});
        end
    endtask

    initial begin
        int req_cycles, err_pulses, err_when;
        logic a, hold;
        i_Reset = 1; i_Mem_Valid = 0; i_Mem_Read_Write_n = 0; i_Mem_Mask = 0;
        i_Kill = 0; i_Mem_Ack = 0; i_Mem_Read_Data = 0;
        t_rst = 1; t_valid = 0; t_ack = 0;
        m_out = 0; m_dead = 0; m_age = 0; m_rw = 0; m_mk = 0;
        m_ldv = 0; m_ld = 0; m_err = 0; m_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Short-timeout instance: load never acked.
        t_rst = 0; t_valid = 1;
        @(posedge clk); #1;
        t_valid = 0;
        req_cycles = 0; err_pulses = 0; err_when = -1;
        for (int c = 0; c < 12; c++) begin
            if (t_req) req_cycles++;
            if (t_err) begin err_pulses++; err_when = c; end
            @(posedge clk); #1;
        end
        chk("to_req_cycles", req_cycles, 4);
        chk("to_err_pulses", err_pulses, 1);
        chk("to_err_cycle", err_when, 4);
        chk("to_idle_req", {31'b0, t_req}, 0);
        chk("to_idle_stall", {31'b0, t_stall}, 0);
        chk("to_no_ldv", {31'b0, t_ldv}, 0);

        // Reset state of main instance.
        chk("rst_req", {31'b0, o_Mem_Req}, 0);
        chk("rst_ldv", {31'b0, o_Load_Data_Valid}, 0);
        chk("rst_err", {31'b0, o_Mem_Error}, 0);
        chk("rst_ld", o_Load_Data, 0);
        chk("rst_cnt", {16'b0, o_Stall_Count}, 0);

        tbl[0]  = mkv(1,1,3'b111,0,0,32'h0,        1,1,0,16'd1, 32'h0);
        tbl[1]  = mkv(1,1,3'b111,0,1,32'hDEADBEEF, 0,0,1,16'd1, 32'hDEADBEEF);
        tbl[2]  = mkv(0,0,3'b000,0,0,32'h0,        0,0,0,16'd1, 32'hDEADBEEF);
        tbl[3]  = mkv(1,0,3'b011,0,0,32'h0,        1,1,0,16'd2, 32'hDEADBEEF);
        for (int i = 4; i <= 8; i++)
            tbl[i] = mkv(1,0,3'b011,0,0,32'h0,     1,1,0,16'(i-1), 32'hDEADBEEF);
        tbl[9]  = mkv(1,0,3'b011,0,1,32'h55AA55AA, 0,0,0,16'd7, 32'hDEADBEEF);
        tbl[10] = mkv(0,0,3'b000,0,0,32'h0,        0,0,0,16'd7, 32'hDEADBEEF);
        tbl[11] = mkv(1,1,3'b111,0,0,32'h0,        1,1,0,16'd8, 32'hDEADBEEF);
        tbl[12] = mkv(1,1,3'b111,0,0,32'h0,        1,1,0,16'd9, 32'hDEADBEEF);
        tbl[13] = mkv(1,1,3'b111,1,0,32'h0,        1,1,0,16'd10,32'hDEADBEEF);
        tbl[14] = mkv(1,1,3'b111,0,0,32'h0,        1,1,0,16'd11,32'hDEADBEEF);
        tbl[15] = mkv(1,1,3'b111,0,0,32'h0,        1,1,0,16'd12,32'hDEADBEEF);
        tbl[16] = mkv(1,1,3'b111,0,1,32'h12345678, 1,0,0,16'd13,32'hDEADBEEF);
        tbl[17] = mkv(0,0,3'b000,0,0,32'h0,        0,0,0,16'd13,32'hDEADBEEF);
        tbl[18] = mkv(1,1,3'b111,1,0,32'h0,        0,0,0,16'd13,32'hDEADBEEF);
        tbl[19] = mkv(1,1,3'b111,1,1,32'h0,        0,0,0,16'd13,32'hDEADBEEF);
        tbl[20] = mkv(0,0,3'b000,0,0,32'h0,        0,0,0,16'd13,32'hDEADBEEF);
        tbl[21] = mkv(1,1,3'b001,0,0,32'h0,        1,1,0,16'd14,32'hDEADBEEF);
        tbl[22] = mkv(1,1,3'b001,1,1,32'hAAAA5555, 1,0,0,16'd15,32'hDEADBEEF);
        tbl[23] = mkv(0,0,3'b000,0,0,32'h0,        0,0,0,16'd15,32'hDEADBEEF);
        tbl[24] = mkv(1,1,3'b111,0,0,32'h0,        1,1,0,16'd16,32'hDEADBEEF);
        tbl[25] = mkv(1,1,3'b111,0,1,32'h0BADF00D, 0,0,1,16'd16,32'h0BADF00D);
        tbl[26] = mkv(1,1,3'b110,0,0,32'h0,        1,1,0,16'd17,32'h0BADF00D);
        tbl[27] = mkv(1,1,3'b110,0,1,32'h00C0FFEE, 0,0,1,16'd17,32'h00C0FFEE);
        tbl[28] = mkv(0,0,3'b000,0,0,32'h0,        0,0,0,16'd17,32'h00C0FFEE);

        for (int i = 0; i < 29; i++) begin
            step(0, tbl[i].v, tbl[i].rw, tbl[i].mk, tbl[i].k, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_stall", i), {31'b0, s_stall}, {31'b0, tbl[i].e_st});
            chk($sformatf("tbl%0d_req", i), {31'b0, o_Mem_Req}, {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d_ldv", i), {31'b0, o_Load_Data_Valid}, {31'b0, tbl[i].e_ldv});
            chk($sformatf("tbl%0d_cnt", i), {16'b0, o_Stall_Count}, {16'b0, tbl[i].e_cnt});
            chk($sformatf("tbl%0d_ld", i), o_Load_Data, tbl[i].e_ld);
        end

        // Random traffic; ack-starved phases let accesses run into the timeout.
        for (int i = 0; i < 3000; i++) begin
            hold = ((i / 500) % 2) == 1;
            a = hold ? ($urandom_range(99) < 2) : ($urandom_range(99) < 35);
            step(0, $urandom_range(99) < 60, 1'($urandom), 3'($urandom),
                 $urandom_range(99) < 10, a, $urandom);
        end

        // Reset in the middle of an access.
        step(1, 0, 0, 3'b000, 0, 0, 32'h0);
        step(0, 1, 1, 3'b101, 0, 0, 32'h0);
        step(0, 1, 1, 3'b101, 0, 0, 32'h0);
        step(1, 1, 1, 3'b101, 0, 0, 32'h0);
        chk("midrst_req", {31'b0, o_Mem_Req}, 0);
        chk("midrst_cnt", {16'b0, o_Stall_Count}, 0);
        chk("midrst_ld", o_Load_Data, 0);
        step(0, 0, 0, 3'b000, 0, 1, 32'hFFFFFFFF);
        chk("idle_ack_req", {31'b0, o_Mem_Req}, 0);
        chk("idle_ack_stall", {31'b0, s_stall}, 0);
        chk("idle_ack_ldv", {31'b0, o_Load_Data_Valid}, 0);

        // Never acked: stall is held continuously across repeated timeouts.
        for (int i = 0; i < 65540; i++)
            step(0, 1, 1, 3'b111, 0, 0, 32'h0);
        chk("cnt_saturated", {16'b0, o_Stall_Count}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
